// File: rtl/spi_pkg.sv
// Shared opcode/state types and frame constants for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CMD,
        SHIFT,
        TURN,
        RECV,
        END
    } spi_state_e;

    // Outgoing command word is {opcode, payload}; incoming read data is one byte.
    localparam int FRAME_BITS = 10;
    localparam int RD_BITS    = 8;

endpackage

// File: rtl/spi_shift_reg.sv
// Datapath shifters for the SPI master.
// The transmit side is a parallel-in/serial-out register.
// The receive side is an 8-bit serial-in/parallel-out shifter.
module spi_shift_reg
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  tx_shift,
    output logic                  tx_msb,
    input  logic                  rx_shift,
    input  logic                  rx_in,
    output logic [RD_BITS-1:0]    rx_word
);

    logic [FRAME_BITS-1:0] tx_q;
    // Only seven bits are stored. The eighth bit is the live serial input.
    // This lets the full byte be captured on the same edge that samples
    // the last bit.
    logic [RD_BITS-2:0]    rx_q;

    assign tx_msb  = tx_q[FRAME_BITS-1];
    assign rx_word = {rx_q, rx_in};

    // Load the command word at frame start, then shift it out MSB first.
    always_ff @(posedge clk) begin
        if (load) begin
            tx_q <= load_word;
        end else if (tx_shift) begin
            tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    // Shift received bits in MSB first.
    // Every bit is overwritten within one read, so no clear is needed.
    always_ff @(posedge clk) begin
        if (rx_shift) begin
            rx_q <= rx_word[RD_BITS-2:0];
        end
    end

endmodule

// File: rtl/spi_master.sv
// Frame-level SPI master.
// Each frame sends one 10-bit {opcode, payload} word.
// Read-data frames then wait a turnaround gap and receive one byte from MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] RECV_LAST  = 4'(RD_BITS - 1);
    localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);

    spi_state_e         state;
    spi_op_e            op;
    logic [3:0]         cnt;
    logic               tx_load;
    logic               tx_shift;
    logic               tx_msb;
    logic               rx_shift;
    logic [RD_BITS-1:0] rx_word;

    // The shifter moves one bit per cycle from CMD through the second-to-last SHIFT cycle.
    // The MOSI register then always picks up the next bit one cycle ahead.
    assign tx_load  = (state == IDLE) && start;
    assign tx_shift = (state == CMD) || ((state == SHIFT) && (cnt != SHIFT_LAST));
    assign rx_shift = (state == RECV);

    spi_shift_reg u_shift (
        .clk       (clk),
        .load      (tx_load),
        .load_word ({cmd_op, cmd_data}),
        .tx_shift  (tx_shift),
        .tx_msb    (tx_msb),
        .rx_shift  (rx_shift),
        .rx_in     (MISO),
        .rx_word   (rx_word)
    );

    // Frame sequencer. Every output is registered and set for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= WR_ADDR;
            cnt      <= '0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SEL;
                        op    <= spi_op_e'(cmd_op);
                        SS_n  <= 1'b0;
                        MOSI  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SEL: begin
                    state <= CMD;
                    MOSI  <= tx_msb;
                end
                CMD: begin
                    state <= SHIFT;
                    MOSI  <= tx_msb;
                    cnt   <= '0;
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (op == RD_DATA) begin
                            state <= (TURNAROUND == 0) ? RECV : TURN;
                        end else begin
                            state <= END;
                            SS_n  <= 1'b1;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + 4'd1;
                        MOSI <= tx_msb;
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt   <= '0;
                        state <= RECV;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RECV: begin
                    if (cnt == RECV_LAST) begin
                        cnt      <= '0;
                        state    <= END;
                        SS_n     <= 1'b1;
                        done     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_data  <= rx_word;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                END: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master, with a small SPI slave/RAM model on the serial pins.
module tb_spi_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int total = 0;
    int bad   = 0;

    // Per-cycle capture of DUT outputs; index k is cycle T+k of the current frame.
    logic       ss_a   [0:40];
    logic       mosi_a [0:40];
    logic       done_a [0:40];
    logic       rv_a   [0:40];
    logic       busy_a [0:40];
    logic [7:0] rd_a   [0:40];

    // Slave model state.
    int         s_idx = 0;
    logic [9:0] s_word = '0;
    logic [7:0] s_addr = '0;
    logic [7:0] ram [0:255];
    bit         use_ram = 1'b0;
    logic [7:0] fixed_byte = 8'h00;
    logic [7:0] miso_byte;

    spi_master #(.TURNAROUND(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: index 0 is the SEL cycle.
    // The word bits arrive at indices 2..11, and read data goes out at indices 14..21.
    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            s_idx = 0;
            MISO  = 1'b0;
        end else begin
            if (s_idx >= 2 && s_idx <= 11) s_word = {s_word[8:0], MOSI};
            if (s_idx == 11) begin
                if (s_word[9:8] == 2'b00 || s_word[9:8] == 2'b10) s_addr = s_word[7:0];
                else if (s_word[9:8] == 2'b01) ram[s_addr] = s_word[7:0];
            end
            miso_byte = use_ram ? ram[s_addr] : fixed_byte;
            if (s_idx >= 14 && s_idx <= 21) MISO = miso_byte[21 - s_idx];
            else MISO = 1'b0;
            s_idx++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got=timeout want=finish");
        $fatal(1);
    end

    // Start a frame from an idle negedge (cycle T) and record n cycles.
    // The command inputs are scrambled right after capture.
    // start and rst can optionally be pulsed at chosen cycles.
    task automatic launch(input logic [1:0] op, input logic [7:0] d, input int n,
                          input int pulse_at, input int rst_at);
        start = 1'b1; cmd_op = op; cmd_data = d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ss_a[k] = SS_n; mosi_a[k] = MOSI; done_a[k] = done;
            rv_a[k] = rd_valid; busy_a[k] = busy; rd_a[k] = rd_data;
            if (k == 1) begin start = 1'b0; cmd_op = ~op; cmd_data = ~d; end
            if (k == pulse_at) start = 1'b1;
            if (k == pulse_at + 1) start = 1'b0;
            if (k == rst_at) rst = 1'b1;
            if (k == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; cmd_op = 2'b11; cmd_data = 8'hFF;
        repeat (3) @(negedge clk);
        total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL reset SS_n got=%b want=1", SS_n); end
        total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL reset MOSI got=%b want=0", MOSI); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset rd_valid got=%b want=0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset rd_data got=%h want=00", rd_data); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || SS_n !== 1'b1) begin
            bad++; $display("FAIL reset_idle busy/SS_n got=%b/%b want=0/1", busy, SS_n);
        end
    endtask

    task automatic test_write_addr();
        logic [10:0] exp_mosi;
        logic        want;
        exp_mosi = 11'b000_0011_1100;
        launch(2'b00, 8'h3C, 15, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            want = (k >= 13);
            total++; if (ss_a[k] !== want) begin bad++; $display("FAIL wr_addr SS_n k=%0d got=%b want=%b", k, ss_a[k], want); end
            want = (k >= 2 && k <= 12) ? exp_mosi[12 - k] : 1'b0;
            total++; if (mosi_a[k] !== want) begin bad++; $display("FAIL wr_addr MOSI k=%0d got=%b want=%b", k, mosi_a[k], want); end
            want = (k == 13);
            total++; if (done_a[k] !== want) begin bad++; $display("FAIL wr_addr done k=%0d got=%b want=%b", k, done_a[k], want); end
            total++; if (rv_a[k] !== 1'b0) begin bad++; $display("FAIL wr_addr rd_valid k=%0d got=%b want=0", k, rv_a[k]); end
            want = (k <= 13);
            total++; if (busy_a[k] !== want) begin bad++; $display("FAIL wr_addr busy k=%0d got=%b want=%b", k, busy_a[k], want); end
        end
    endtask

    task automatic test_ignore_start();
        logic [10:0] exp_mosi;
        logic        want;
        int          n_done;
        exp_mosi = 11'b001_1000_0001;
        n_done = 0;
        launch(2'b01, 8'h81, 16, 5, 0);
        for (int k = 1; k <= 16; k++) begin
            if (done_a[k] === 1'b1) n_done++;
            want = (k >= 13);
            total++; if (ss_a[k] !== want) begin bad++; $display("FAIL ign_start SS_n k=%0d got=%b want=%b", k, ss_a[k], want); end
            want = (k >= 2 && k <= 12) ? exp_mosi[12 - k] : 1'b0;
            total++; if (mosi_a[k] !== want) begin bad++; $display("FAIL ign_start MOSI k=%0d got=%b want=%b", k, mosi_a[k], want); end
        end
        total++; if (n_done != 1) begin bad++; $display("FAIL ign_start done_count got=%0d want=1", n_done); end
        total++; if (done_a[13] !== 1'b1) begin bad++; $display("FAIL ign_start done_at_13 got=%b want=1", done_a[13]); end
        total++; if (busy_a[16] !== 1'b0) begin bad++; $display("FAIL ign_start busy_after got=%b want=0", busy_a[16]); end
    endtask

    task automatic test_reset_mid_frame();
        logic want;
        launch(2'b11, 8'h00, 12, 0, 6);
        for (int k = 1; k <= 12; k++) begin
            want = (k >= 7);
            total++; if (ss_a[k] !== want) begin bad++; $display("FAIL rst_mid SS_n k=%0d got=%b want=%b", k, ss_a[k], want); end
            total++; if (busy_a[k] !== ~want) begin bad++; $display("FAIL rst_mid busy k=%0d got=%b want=%b", k, busy_a[k], ~want); end
            total++; if (done_a[k] !== 1'b0 || rv_a[k] !== 1'b0) begin
                bad++; $display("FAIL rst_mid done/rd_valid k=%0d got=%b/%b want=0/0", k, done_a[k], rv_a[k]);
            end
            total++; if (rd_a[k] !== 8'h00) begin bad++; $display("FAIL rst_mid rd_data k=%0d got=%h want=00", k, rd_a[k]); end
        end
    endtask

    task automatic test_read_data();
        logic [10:0] exp_mosi;
        logic        want;
        exp_mosi = 11'b111_0000_0000;
        use_ram = 1'b0; fixed_byte = 8'hA5;
        launch(2'b11, 8'h00, 25, 0, 0);
        for (int k = 1; k <= 25; k++) begin
            want = (k >= 23);
            total++; if (ss_a[k] !== want) begin bad++; $display("FAIL rd_data SS_n k=%0d got=%b want=%b", k, ss_a[k], want); end
            want = (k >= 2 && k <= 12) ? exp_mosi[12 - k] : 1'b0;
            total++; if (mosi_a[k] !== want) begin bad++; $display("FAIL rd_data MOSI k=%0d got=%b want=%b", k, mosi_a[k], want); end
            want = (k == 23);
            total++; if (done_a[k] !== want || rv_a[k] !== want) begin
                bad++; $display("FAIL rd_data done/rd_valid k=%0d got=%b/%b want=%b/%b", k, done_a[k], rv_a[k], want, want);
            end
        end
        total++; if (rd_a[22] !== 8'h00) begin bad++; $display("FAIL rd_data early_update got=%h want=00", rd_a[22]); end
        total++; if (rd_a[23] !== 8'hA5) begin bad++; $display("FAIL rd_data value got=%h want=a5", rd_a[23]); end
        total++; if (rd_a[25] !== 8'hA5) begin bad++; $display("FAIL rd_data hold got=%h want=a5", rd_a[25]); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp1, exp2;
        logic        want;
        int          n_done;
        exp1 = 11'b000_0011_1100;
        exp2 = 11'b110_0111_0111;
        n_done = 0;
        start = 1'b1; cmd_op = 2'b00; cmd_data = 8'h3C;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            ss_a[k] = SS_n; mosi_a[k] = MOSI; done_a[k] = done;
            if (k == 1) begin cmd_op = 2'b10; cmd_data = 8'h77; end
            if (k == 15) start = 1'b0;
        end
        for (int k = 1; k <= 30; k++) begin
            if (done_a[k] === 1'b1) n_done++;
            want = (k == 13 || k == 14 || k >= 27);
            total++; if (ss_a[k] !== want) begin bad++; $display("FAIL b2b SS_n k=%0d got=%b want=%b", k, ss_a[k], want); end
            if (k >= 2 && k <= 12) want = exp1[12 - k];
            else if (k >= 16 && k <= 26) want = exp2[26 - k];
            else want = 1'b0;
            total++; if (mosi_a[k] !== want) begin bad++; $display("FAIL b2b MOSI k=%0d got=%b want=%b", k, mosi_a[k], want); end
        end
        total++; if (n_done != 2) begin bad++; $display("FAIL b2b done_count got=%0d want=2", n_done); end
        total++; if (done_a[13] !== 1'b1 || done_a[27] !== 1'b1) begin
            bad++; $display("FAIL b2b done_pos got=%b/%b want=1/1", done_a[13], done_a[27]);
        end
    endtask

    task automatic test_end_to_end();
        use_ram = 1'b1;
        launch(2'b00, 8'h10, 14, 0, 0);
        launch(2'b01, 8'h5A, 14, 0, 0);
        launch(2'b10, 8'h10, 14, 0, 0);
        launch(2'b11, 8'h00, 24, 0, 0);
        total++; if (rd_a[23] !== 8'h5A) begin bad++; $display("FAIL e2e rd_data got=%h want=5a", rd_a[23]); end
        total++; if (rv_a[23] !== 1'b1 || done_a[23] !== 1'b1) begin
            bad++; $display("FAIL e2e rd_valid/done got=%b/%b want=1/1", rv_a[23], done_a[23]);
        end
    endtask

    task automatic test_rd_hold();
        launch(2'b00, 8'hFF, 14, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            total++; if (rd_a[k] !== 8'h5A) begin bad++; $display("FAIL rd_hold rd_data k=%0d got=%h want=5a", k, rd_a[k]); end
            total++; if (rv_a[k] !== 1'b0) begin bad++; $display("FAIL rd_hold rd_valid k=%0d got=%b want=0", k, rv_a[k]); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        test_reset();
        test_write_addr();
        test_ignore_start();
        test_reset_mid_frame();
        test_read_data();
        test_back_to_back();
        test_end_to_end();
        test_rd_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
